// File: rtl/gpr_pkg.sv
// gpr_pkg: shared widths and writeback source tag for the GPR writeback path
package gpr_pkg;
    localparam int XLEN       = 64;
    localparam int NREG       = 32;
    localparam int REG_ADDR_W = 5;
    typedef enum logic {WB_ALU, WB_LSU} wb_src_e;
endpackage

// File: rtl/gpr_scoreboard.sv
// gpr_scoreboard: busy bits for registers awaiting load data, with two source read ports
module gpr_scoreboard
    import gpr_pkg::*;
#(
    parameter int NREG = gpr_pkg::NREG
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_set,
    input  logic [REG_ADDR_W-1:0] i_set_addr,
    output logic                  o_set_ready,
    input  logic                  i_clr,
    input  logic [REG_ADDR_W-1:0] i_clr_addr,
    input  logic [REG_ADDR_W-1:0] i_rs1_addr,
    input  logic [REG_ADDR_W-1:0] i_rs2_addr,
    output logic                  o_rs1_busy,
    output logic                  o_rs2_busy
);
    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_nxt;

    assign o_set_ready = !rst && !r_busy[i_set_addr];
    assign o_rs1_busy  = r_busy[i_rs1_addr];
    assign o_rs2_busy  = r_busy[i_rs2_addr];

    // Clear from the LSU writeback and set from issue; x0 is never busy
    always_comb begin
        w_busy_nxt = r_busy;
        if (i_clr) w_busy_nxt[i_clr_addr] = 1'b0;
        if (i_set && o_set_ready) w_busy_nxt[i_set_addr] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    // Busy vector register
    always_ff @(posedge clk) begin
        if (rst) r_busy <= '0;
        else     r_busy <= w_busy_nxt;
    end
endmodule

// File: rtl/gpr_wb_arbiter.sv
// gpr_wb_arbiter: round-robin ALU/LSU arbiter for the GPR write port with load scoreboard
module gpr_wb_arbiter
    import gpr_pkg::*;
#(
    parameter int XLEN  = gpr_pkg::XLEN,
    parameter int NREG  = gpr_pkg::NREG,
    parameter int CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [REG_ADDR_W-1:0] alu_waddr,
    input  logic [XLEN-1:0]       alu_wdata,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [REG_ADDR_W-1:0] lsu_waddr,
    input  logic [XLEN-1:0]       lsu_wdata,
    input  logic                  sb_set,
    input  logic [REG_ADDR_W-1:0] sb_set_addr,
    output logic                  sb_set_ready,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic                  rf_wen,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]       rf_wdata,
    output logic [CNT_W-1:0]      conflict_cnt
);
    logic                  w_both;
    logic                  w_wr;
    logic [REG_ADDR_W-1:0] w_addr;
    logic [XLEN-1:0]       w_data;
    wb_src_e               w_src;
    logic                  r_p;
    logic                  r_wen;
    logic [REG_ADDR_W-1:0] r_waddr;
    logic [XLEN-1:0]       r_wdata;
    wb_src_e               r_src;
    logic [CNT_W-1:0]      r_cnt;

    assign w_both    = alu_valid && lsu_valid;
    assign alu_ready = !rst && alu_valid && !(lsu_valid && r_p);
    assign lsu_ready = !rst && lsu_valid && !(alu_valid && !r_p);
    assign w_src     = lsu_ready ? WB_LSU : WB_ALU;
    assign w_addr    = lsu_ready ? lsu_waddr : alu_waddr;
    assign w_data    = lsu_ready ? lsu_wdata : alu_wdata;
    assign w_wr      = (alu_ready || lsu_ready) && w_addr != '0;

    assign rf_wen       = r_wen;
    assign rf_waddr     = r_waddr;
    assign rf_wdata     = r_wdata;
    assign conflict_cnt = r_cnt;

    // Output register stage, round-robin priority and conflict counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wen   <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_src   <= WB_ALU;
            r_p     <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_wen <= w_wr;
            if (w_wr) begin
                r_waddr <= w_addr;
                r_wdata <= w_data;
                r_src   <= w_src;
            end
            if (w_both) begin
                r_p   <= !r_p;
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    gpr_scoreboard #(.NREG(NREG)) u_sb (
        .clk         (clk),
        .rst         (rst),
        .i_set       (sb_set),
        .i_set_addr  (sb_set_addr),
        .o_set_ready (sb_set_ready),
        .i_clr       (r_wen && r_src == WB_LSU),
        .i_clr_addr  (r_waddr),
        .i_rs1_addr  (rs1_addr),
        .i_rs2_addr  (rs2_addr),
        .o_rs1_busy  (rs1_busy),
        .o_rs2_busy  (rs2_busy)
    );
endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// tb_gpr_wb_arbiter: table vectors, directed corner sequences and random traffic against a reference model
module tb_gpr_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid, lsu_valid, sb_set;
    logic        alu_ready, lsu_ready, sb_set_ready, rs1_busy, rs2_busy, rf_wen;
    logic [4:0]  alu_waddr, lsu_waddr, sb_set_addr, rs1_addr, rs2_addr, rf_waddr;
    logic [63:0] alu_wdata, lsu_wdata, rf_wdata;
    logic [31:0] conflict_cnt;
    logic [63:0] rf_mem [32];

    int n_cmp = 0;
    int n_bad = 0;

    bit          m_p, m_wen, m_lsu, m_ga, m_gl;
    bit [4:0]    m_waddr;
    bit [63:0]   m_wdata;
    bit [31:0]   m_cnt;
    bit          m_busy [32];

    typedef struct {
        bit av; bit [4:0] aa; bit [63:0] ad;
        bit lv; bit [4:0] la; bit [63:0] ld;
        bit ss; bit [4:0] sa; bit [4:0] r1;
        bit e_ar; bit e_lr; bit e_sr; bit e_r1b; bit e_wen; bit [4:0] e_wa;
    } vec_t;
    vec_t tbl [11];

    always #5 clk = ~clk;

    always @(posedge clk) if (rf_wen) rf_mem[rf_waddr] <= rf_wdata;

    gpr_wb_arbiter #(.XLEN(64), .NREG(32), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_waddr(lsu_waddr), .lsu_wdata(lsu_wdata),
        .sb_set(sb_set), .sb_set_addr(sb_set_addr), .sb_set_ready(sb_set_ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .conflict_cnt(conflict_cnt)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        alu_valid = 0; alu_waddr = 0; alu_wdata = 0;
        lsu_valid = 0; lsu_waddr = 0; lsu_wdata = 0;
        sb_set = 0; sb_set_addr = 0; rs1_addr = 0; rs2_addr = 0;
    endtask

    // one clock: check combinational outputs against the model, advance model, check registered outputs
    task automatic tick();
        bit ga, gl, sr;
        bit [4:0] a;
        #1;
        ga = 0; gl = 0; sr = 0;
        if (!rst) begin
            if (alu_valid && lsu_valid) begin
                ga = !m_p;
                gl = m_p;
            end else begin
                ga = alu_valid;
                gl = lsu_valid;
            end
            sr = !m_busy[sb_set_addr];
        end
        chk("alu_ready", alu_ready, ga);
        chk("lsu_ready", lsu_ready, gl);
        chk("sb_set_ready", sb_set_ready, sr);
        chk("rs1_busy", rs1_busy, m_busy[rs1_addr]);
        chk("rs2_busy", rs2_busy, m_busy[rs2_addr]);
        m_ga = ga;
        m_gl = gl;
        @(posedge clk);
        if (rst) begin
            m_p = 0; m_wen = 0; m_lsu = 0; m_waddr = 0; m_wdata = 0; m_cnt = 0;
            foreach (m_busy[i]) m_busy[i] = 0;
        end else begin
            if (m_wen && m_lsu) m_busy[m_waddr] = 0;
            if (sb_set && sr && sb_set_addr != 0) m_busy[sb_set_addr] = 1;
            a = ga ? alu_waddr : lsu_waddr;
            m_wen = (ga || gl) && a != 0;
            if (m_wen) begin
                m_waddr = a;
                m_wdata = ga ? alu_wdata : lsu_wdata;
                m_lsu = gl;
            end
            if (alu_valid && lsu_valid) begin
                m_p = !m_p;
                m_cnt = m_cnt + 1;
            end
        end
        #1;
        chk("rf_wen", rf_wen, m_wen);
        chk("rf_waddr", rf_waddr, m_waddr);
        chk("rf_wdata", rf_wdata, m_wdata);
        chk("conflict_cnt", conflict_cnt, m_cnt);
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    initial begin
        tbl[0]  = '{1, 5, 64'hDEAD_BEEF, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 1, 5};
        tbl[1]  = '{1, 0, 64'h55,        0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 5};
        tbl[2]  = '{0, 0, 0,             0, 0, 0, 1, 0, 0,  0, 0, 1, 0, 0, 5};
        tbl[3]  = '{0, 0, 0,             0, 0, 0, 1, 9, 9,  0, 0, 1, 0, 0, 5};
        tbl[4]  = '{0, 0, 0,             0, 0, 0, 1, 9, 9,  0, 0, 0, 1, 0, 5};
        tbl[5]  = '{0, 0, 0,             1, 9, 64'h99, 1, 9, 9,  0, 1, 0, 1, 1, 9};
        tbl[6]  = '{0, 0, 0,             0, 0, 0, 1, 9, 9,  0, 0, 0, 1, 0, 9};
        tbl[7]  = '{0, 0, 0,             0, 0, 0, 1, 9, 9,  0, 0, 1, 0, 0, 9};
        tbl[8]  = '{0, 0, 0,             0, 0, 0, 0, 9, 9,  0, 0, 0, 1, 0, 9};
        tbl[9]  = '{1, 1, 64'h1,         1, 2, 64'h2, 0, 0, 9,  1, 0, 1, 1, 1, 1};
        tbl[10] = '{1, 1, 64'h3,         1, 2, 64'h2, 0, 0, 9,  0, 1, 1, 1, 1, 2};

        idle();
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        chk("rst_wen", rf_wen, 0);
        chk("rst_waddr", rf_waddr, 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_cnt", conflict_cnt, 0);

        for (int i = 0; i < 11; i++) begin
            idle();
            alu_valid = tbl[i].av; alu_waddr = tbl[i].aa; alu_wdata = tbl[i].ad;
            lsu_valid = tbl[i].lv; lsu_waddr = tbl[i].la; lsu_wdata = tbl[i].ld;
            sb_set = tbl[i].ss; sb_set_addr = tbl[i].sa; rs1_addr = tbl[i].r1;
            #1;
            chk($sformatf("t%0d_alu_ready", i), alu_ready, tbl[i].e_ar);
            chk($sformatf("t%0d_lsu_ready", i), lsu_ready, tbl[i].e_lr);
            chk($sformatf("t%0d_sb_set_ready", i), sb_set_ready, tbl[i].e_sr);
            chk($sformatf("t%0d_rs1_busy", i), rs1_busy, tbl[i].e_r1b);
            tick();
            chk($sformatf("t%0d_rf_wen", i), rf_wen, tbl[i].e_wen);
            chk($sformatf("t%0d_rf_waddr", i), rf_waddr, tbl[i].e_wa);
        end
        chk("t_rf_wdata_x5", rf_mem[5], 64'hDEAD_BEEF);
        chk("t_cnt", conflict_cnt, 2);

        do_reset();
        alu_valid = 1; alu_waddr = 1; alu_wdata = 64'hA0;
        lsu_valid = 1; lsu_waddr = 2; lsu_wdata = 64'hB0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("cont%0d_alu_ready", k), alu_ready, (k % 2) == 0);
            chk($sformatf("cont%0d_lsu_ready", k), lsu_ready, (k % 2) == 1);
            tick();
            if (k % 2 == 0) alu_wdata = alu_wdata + 1;
            else            lsu_wdata = lsu_wdata + 1;
        end
        chk("cont_cnt", conflict_cnt, 4);

        do_reset();
        sb_set = 1; sb_set_addr = 7; rs1_addr = 7;
        #1;
        chk("raw_c0_busy", rs1_busy, 0);
        tick();
        idle(); rs1_addr = 7;
        #1;
        chk("raw_c1_busy", rs1_busy, 1);
        tick();
        tick();
        lsu_valid = 1; lsu_waddr = 7; lsu_wdata = 64'h1234;
        #1;
        chk("raw_c3_lsu_ready", lsu_ready, 1);
        tick();
        idle(); rs1_addr = 7;
        #1;
        chk("raw_c4_busy", rs1_busy, 1);
        chk("raw_c4_wen", rf_wen, 1);
        tick();
        #1;
        chk("raw_c5_busy", rs1_busy, 0);
        chk("raw_c5_rf", rf_mem[7], 64'h1234);
        tick();

        do_reset();
        sb_set = 1; sb_set_addr = 3;
        tick();
        idle();
        lsu_valid = 1; lsu_waddr = 3; lsu_wdata = 64'h33;
        tick();
        idle();
        rst = 1;
        #1;
        chk("rmw_n1_wen", rf_wen, 1);
        tick();
        rst = 0;
        alu_valid = 1; alu_waddr = 4; alu_wdata = 64'h44;
        lsu_valid = 1; lsu_waddr = 6; lsu_wdata = 64'h66;
        rs1_addr = 3;
        #1;
        chk("rmw_n2_wen", rf_wen, 0);
        chk("rmw_n2_busy", rs1_busy, 0);
        chk("rmw_n2_p0", alu_ready, 1);
        tick();

        idle();
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            if (!alu_valid || m_ga) begin
                alu_valid = $urandom_range(0, 1) == 1;
                alu_waddr = 5'($urandom);
                alu_wdata = {$urandom, $urandom};
            end
            if (!lsu_valid || m_gl) begin
                int s;
                lsu_valid = $urandom_range(0, 1) == 1;
                lsu_waddr = 5'($urandom);
                lsu_wdata = {$urandom, $urandom};
                s = $urandom_range(0, 31);
                if ($urandom_range(0, 3) != 0)
                    for (int k = 0; k < 32; k++)
                        if (m_busy[(s + k) % 32]) begin
                            lsu_waddr = 5'((s + k) % 32);
                            break;
                        end
            end
            sb_set = $urandom_range(0, 2) == 0;
            sb_set_addr = 5'($urandom);
            rs1_addr = 5'($urandom);
            rs2_addr = 5'($urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
